// File: rtl/clear_pkg.sv
// Shared types and helpers for the frame-clear handshake responder.
// Holds the FSM encoding and the shared drain/flush timer sizing.
package clear_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Timer holds at most max(TIMEOUT, CLR_CYCLES)-1.
    function automatic int tmr_width(input int timeout, input int clr_cycles);
        int m;
        m = (timeout > clr_cycles) ? timeout : clr_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/clear_handshake_responder_bit_sync.sv
// N-flop single-bit synchronizer, async active-low reset.
// Reusable on the source side for the returned acknowledge.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/clear_handshake_responder.sv
// Target-domain responder for the camera frame-clear req/ack handshake.
// Syncs the request, drains the writer, flushes, then acks and flips bank.
module clear_handshake_responder
    import clear_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CLR_CYCLES  = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clock_target,
    input  logic             rst_n,
    input  logic             clear_req_async,
    input  logic             wr_busy,
    output logic             clear_ack,
    output logic             fifo_clr,
    output logic             frame_start,
    output logic             bank_sel,
    output logic [CNT_W-1:0] clear_count,
    output logic             timeout_err
);

    localparam int TMR_W = tmr_width(TIMEOUT, CLR_CYCLES);
    localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(CLR_CYCLES - 1);

    logic req_s;

    bit_sync #(
        .N(SYNC_STAGES)
    ) u_req_sync (
        .clk  (clock_target),
        .rst_n(rst_n),
        .d    (clear_req_async),
        .q    (req_s)
    );

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             clear_ack_q, clear_ack_d;
    logic             fifo_clr_q, fifo_clr_d;
    logic             frame_start_q, frame_start_d;
    logic             bank_sel_q, bank_sel_d;
    logic [CNT_W-1:0] clear_count_q, clear_count_d;
    logic             timeout_err_q, timeout_err_d;
    logic             tmr_zero;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        bank_sel_d    = bank_sel_q;
        clear_count_d = clear_count_q;
        timeout_err_d = timeout_err_q;
        tmr_zero      = (tmr_q == '0);

        unique case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = DRAIN;
                    tmr_d   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (!wr_busy || tmr_zero) begin
                    state_d = FLUSH;
                    tmr_d   = FLUSH_LOAD;
                    if (wr_busy) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            FLUSH: begin
                if (tmr_zero) begin
                    state_d    = ACK;
                    bank_sel_d = ~bank_sel_q;
                    if (clear_count_q != '1) begin
                        clear_count_d = clear_count_q + CNT_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the next state.
        fifo_clr_d    = (state_d == FLUSH);
        clear_ack_d   = (state_d == ACK);
        frame_start_d = (state_d == ACK) && (state_q != ACK);
    end

    always_ff @(posedge clock_target or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            clear_ack_q   <= 1'b0;
            fifo_clr_q    <= 1'b0;
            frame_start_q <= 1'b0;
            bank_sel_q    <= 1'b0;
            clear_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            clear_ack_q   <= clear_ack_d;
            fifo_clr_q    <= fifo_clr_d;
            frame_start_q <= frame_start_d;
            bank_sel_q    <= bank_sel_d;
            clear_count_q <= clear_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign clear_ack   = clear_ack_q;
    assign fifo_clr    = fifo_clr_q;
    assign frame_start = frame_start_q;
    assign bank_sel    = bank_sel_q;
    assign clear_count = clear_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_clear_handshake_responder.sv
// Directed bench for clear_handshake_responder.
// SYNC_STAGES=2, CLR_CYCLES=4, TIMEOUT=8.
module tb_clear_handshake_responder;

    logic        clk;
    logic        rst_n;
    logic        clear_req_async;
    logic        wr_busy;
    logic        clear_ack;
    logic        fifo_clr;
    logic        frame_start;
    logic        bank_sel;
    logic [15:0] clear_count;
    logic        timeout_err;

    int errors;
    int checks;

    typedef struct {
        int first_clr;
        int clr_len;
        int first_ack;
        int ack_len;
        int fs_cnt;
        int drop_n;
        int fall_n;
        int clr_after_ack;
    } obs_t;

    clear_handshake_responder #(
        .SYNC_STAGES(2),
        .CLR_CYCLES (4),
        .TIMEOUT    (8)
    ) dut (
        .clock_target   (clk),
        .rst_n          (rst_n),
        .clear_req_async(clear_req_async),
        .wr_busy        (wr_busy),
        .clear_ack      (clear_ack),
        .fifo_clr       (fifo_clr),
        .frame_start    (frame_start),
        .bank_sel       (bank_sel),
        .clear_count    (clear_count),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise the request, then observe one handshake sampled at negedges.
    // req_drop_n: 0 = drop on first ack, >0 = drop at that cycle, <0 = hold.
    task automatic watch(input int busy_drop_n, input int req_drop_n,
                         input int max_n, output obs_t o);
        o = '{-1, 0, -1, 0, 0, -1, -1, 0};
        clear_req_async = 1'b1;
        for (int n = 1; n <= max_n; n++) begin
            @(negedge clk);
            if (fifo_clr) begin
                if (o.first_clr < 0) o.first_clr = n;
                o.clr_len++;
                if (o.first_ack >= 0) o.clr_after_ack++;
            end
            if (frame_start) o.fs_cnt++;
            if (clear_ack) begin
                if (o.first_ack < 0) o.first_ack = n;
                o.ack_len++;
            end else if (o.first_ack >= 0) begin
                o.fall_n = n;
                break;
            end
            if (n == busy_drop_n) wr_busy = 1'b0;
            if (clear_req_async &&
                ((req_drop_n == 0 && o.first_ack >= 0) ||
                 (req_drop_n > 0 && n == req_drop_n))) begin
                clear_req_async = 1'b0;
                o.drop_n = n;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_req_async = 1'b0;
        wr_busy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({clear_ack, fifo_clr, frame_start, bank_sel, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {clear_ack, fifo_clr, frame_start, bank_sel, timeout_err});
        end
        checks++;
        if (clear_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_count: got %h expected 0000", clear_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        obs_t o;
        watch(0, 0, 40, o);
        checks++;
        if (o.first_clr !== 4) begin
            errors++;
            $display("FAIL basic_clr_start: got %0d expected 4", o.first_clr);
        end
        checks++;
        if (o.clr_len !== 4) begin
            errors++;
            $display("FAIL basic_clr_len: got %0d expected 4", o.clr_len);
        end
        checks++;
        if (o.first_ack !== 8) begin
            errors++;
            $display("FAIL basic_ack_latency: got %0d expected 8", o.first_ack);
        end
        checks++;
        if (o.fs_cnt !== 1) begin
            errors++;
            $display("FAIL basic_frame_start: got %0d pulses expected 1", o.fs_cnt);
        end
        checks++;
        if (o.fall_n - o.drop_n !== 3) begin
            errors++;
            $display("FAIL basic_ack_fall: got %0d edges expected 3",
                     o.fall_n - o.drop_n);
        end
        checks++;
        if (bank_sel !== 1'b1 || clear_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_bank_count: got bank=%b count=%0d expected bank=1 count=1",
                     bank_sel, clear_count);
        end
    endtask

    task automatic test_drain_wait();
        obs_t o;
        wr_busy = 1'b1;
        watch(8, 0, 40, o);
        checks++;
        if (o.first_clr !== 9) begin
            errors++;
            $display("FAIL drain_clr_start: got %0d expected 9", o.first_clr);
        end
        checks++;
        if (o.first_ack !== 13 || o.clr_len !== 4) begin
            errors++;
            $display("FAIL drain_ack: got ack=%0d len=%0d expected ack=13 len=4",
                     o.first_ack, o.clr_len);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL drain_no_timeout: got %b expected 0", timeout_err);
        end
        checks++;
        if (bank_sel !== 1'b0 || clear_count !== 16'd2) begin
            errors++;
            $display("FAIL drain_bank_count: got bank=%b count=%0d expected bank=0 count=2",
                     bank_sel, clear_count);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        wr_busy = 1'b1;
        watch(0, 0, 40, o);
        checks++;
        if (o.first_clr !== 11) begin
            errors++;
            $display("FAIL timeout_clr_start: got %0d expected 11", o.first_clr);
        end
        checks++;
        if (o.first_ack !== 15 || o.clr_len !== 4) begin
            errors++;
            $display("FAIL timeout_ack: got ack=%0d len=%0d expected ack=15 len=4",
                     o.first_ack, o.clr_len);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got %b expected 1", timeout_err);
        end
        wr_busy = 1'b0;
        watch(0, 0, 40, o);
        checks++;
        if (o.first_ack !== 8 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got ack=%0d err=%b expected ack=8 err=1",
                     o.first_ack, timeout_err);
        end
        checks++;
        if (clear_count !== 16'd4) begin
            errors++;
            $display("FAIL timeout_count: got %0d expected 4", clear_count);
        end
    endtask

    task automatic test_abort();
        obs_t o;
        watch(0, 5, 40, o);
        checks++;
        if (o.clr_len !== 4 || o.first_ack !== 8) begin
            errors++;
            $display("FAIL abort_flush: got len=%0d ack=%0d expected len=4 ack=8",
                     o.clr_len, o.first_ack);
        end
        checks++;
        if (o.ack_len !== 1) begin
            errors++;
            $display("FAIL abort_ack_len: got %0d expected 1", o.ack_len);
        end
        checks++;
        if (clear_count !== 16'd5 || bank_sel !== 1'b1) begin
            errors++;
            $display("FAIL abort_count: got count=%0d bank=%b expected count=5 bank=1",
                     clear_count, bank_sel);
        end
    endtask

    task automatic test_reset_mid_flush();
        obs_t o;
        clear_req_async = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (fifo_clr !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_flush: got fifo_clr=%b expected 1", fifo_clr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_clr, clear_ack, bank_sel, timeout_err} !== 4'b0 ||
            clear_count !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: got clr=%b ack=%b bank=%b err=%b count=%0d expected all 0",
                     fifo_clr, clear_ack, bank_sel, timeout_err, clear_count);
        end
        clear_req_async = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        watch(0, 0, 40, o);
        checks++;
        if (o.first_ack !== 8 || o.clr_len !== 4) begin
            errors++;
            $display("FAIL rst_rerun: got ack=%0d len=%0d expected ack=8 len=4",
                     o.first_ack, o.clr_len);
        end
        checks++;
        if (clear_count !== 16'd1 || bank_sel !== 1'b1) begin
            errors++;
            $display("FAIL rst_rerun_count: got count=%0d bank=%b expected count=1 bank=1",
                     clear_count, bank_sel);
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        logic exp_bank;
        exp_bank = bank_sel;
        @(negedge clk);
        force dut.clear_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.clear_count_q;
        @(negedge clk);
        checks++;
        if (clear_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload: got %h expected fffe", clear_count);
        end
        for (int k = 0; k < 2; k++) begin
            watch(0, 0, 40, o);
            exp_bank = ~exp_bank;
            checks++;
            if (clear_count !== 16'hFFFF || bank_sel !== exp_bank) begin
                errors++;
                $display("FAIL sat_run%0d: got count=%h bank=%b expected count=ffff bank=%b",
                         k, clear_count, bank_sel, exp_bank);
            end
        end
        watch(0, -1, 30, o);
        exp_bank = ~exp_bank;
        checks++;
        if (o.first_ack !== 8 || o.clr_after_ack !== 0 || o.fs_cnt !== 1) begin
            errors++;
            $display("FAIL held_no_reservice: got ack=%0d reclr=%0d fs=%0d expected 8 0 1",
                     o.first_ack, o.clr_after_ack, o.fs_cnt);
        end
        checks++;
        if (clear_ack !== 1'b1 || clear_count !== 16'hFFFF || bank_sel !== exp_bank) begin
            errors++;
            $display("FAIL held_state: got ack=%b count=%h bank=%b expected 1 ffff %b",
                     clear_ack, clear_count, bank_sel, exp_bank);
        end
        clear_req_async = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (clear_ack !== 1'b0) begin
            errors++;
            $display("FAIL held_release: got ack=%b expected 0", clear_ack);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_drain_wait();
        test_timeout();
        test_abort();
        test_reset_mid_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
